// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, request latch
// layout and the requester id.
package mem_arb_pkg;

    localparam int unsigned REQ_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // 0 = instruction fetch, 1 = load/store unit
    typedef logic port_id_t;

    typedef struct packed {
        logic                      write;
        logic [REQ_DATA_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port that did not win last time
// is granted; last_grant only moves when a grant is actually taken.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    input  port_id_t   update_id,
    output logic [1:0] grant
);

    port_id_t last_grant;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= update_id;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches
    // even when no branch below overrides it.
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch
// (port 0) and the load/store unit (port 1), one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = REQ_DATA_WIDTH,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid_i,
    input  logic                  req0_write_i,
    input  logic [DATA_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  req0_ready_o,
    output logic                  resp0_valid_o,
    output logic [DATA_WIDTH-1:0] resp0_rdata_o,

    input  logic                  req1_valid_i,
    input  logic                  req1_write_i,
    input  logic [DATA_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  req1_ready_o,
    output logic                  resp1_valid_o,
    output logic [DATA_WIDTH-1:0] resp1_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  busy_o
);

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    mem_req_t              req_q;
    mem_req_t              req_in;
    port_id_t              port_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [1:0]            grant;
    logic                  hs0;
    logic                  hs1;
    logic                  handshake;
    logic                  last_beat;

    assign hs0       = req0_valid_i & req0_ready_o;
    assign hs1       = req1_valid_i & req1_ready_o;
    assign handshake = hs0 | hs1;
    assign last_beat = (state == ACCESS) && (cnt == CNT_WIDTH'(MEM_LATENCY - 1));

    rr_arbiter2 u_rr_arbiter2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     ({req1_valid_i, req0_valid_i}),
        .update    (handshake),
        .update_id (hs1),
        .grant     (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (handshake) next_state = ACCESS;
            ACCESS:  if (last_beat) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is qualified by rst_n so both readies read 0 while reset is held.
    always_comb begin
        req0_ready_o  = rst_n && (state == IDLE) && grant[0];
        req1_ready_o  = rst_n && (state == IDLE) && grant[1];
        mem_en_o      = (state == ACCESS);
        mem_we_o      = (state == ACCESS) && req_q.write;
        resp0_valid_o = (state == RESP) && (port_q == 1'b0);
        resp1_valid_o = (state == RESP) && (port_q == 1'b1);
        busy_o        = (state != IDLE);
    end

    always_comb begin
        req_in = hs1 ? '{write: req1_write_i, addr: req1_addr_i, wdata: req1_wdata_i}
                     : '{write: req0_write_i, addr: req0_addr_i, wdata: req0_wdata_i};
    end

    // NOTE: the datapath registers are reset too, because every one of them
    // drives an output that must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            port_q   <= 1'b0;
            cnt      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (handshake) begin
                req_q  <= req_in;
                port_q <= hs1;
                cnt    <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            // Writes acknowledge with zero data; each port keeps its own
            // last response so the idle port's bus does not change.
            if (last_beat) begin
                if (port_q) begin
                    rdata1_q <= req_q.write ? '0 : mem_rdata_i;
                end else begin
                    rdata0_q <= req_q.write ? '0 : mem_rdata_i;
                end
            end
        end
    end

    assign mem_addr_o    = req_q.addr;
    assign mem_wdata_o   = req_q.wdata;
    assign resp0_rdata_o = rdata0_q;
    assign resp1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and a small
// fixed-latency memory model.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_write, req0_ready, resp0_valid;
    logic [31:0] req0_addr, req0_wdata, resp0_rdata;
    logic        req1_valid, req1_write, req1_ready, resp1_valid;
    logic [31:0] req1_addr, req1_wdata, resp1_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_resp   = 0;
    int unsigned cyc_cnt  = 0;
    int unsigned last_rdy = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] ref_mem [int];
    logic [31:0] dut_mem [0:63];
    logic [63:0] dut_wr = '0;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(LAT), .CNT_WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_write_i  (req0_write),
        .req0_addr_i   (req0_addr),
        .req0_wdata_i  (req0_wdata),
        .req0_ready_o  (req0_ready),
        .resp0_valid_o (resp0_valid),
        .resp0_rdata_o (resp0_rdata),
        .req1_valid_i  (req1_valid),
        .req1_write_i  (req1_write),
        .req1_addr_i   (req1_addr),
        .req1_wdata_i  (req1_wdata),
        .req1_ready_o  (req1_ready),
        .resp1_valid_o (resp1_valid),
        .resp1_rdata_o (resp1_rdata),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hA500_0000 | a);
    endfunction

    // Memory: writes land on the clock edge, read data settles mid-cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            dut_mem[mem_addr[7:2]] <= mem_wdata;
            dut_wr[mem_addr[7:2]]  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        mem_rdata <= dut_wr[mem_addr[7:2]] ? dut_mem[mem_addr[7:2]] : init_word(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x.port = p;
        x.data = w ? 32'h0 : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a));
        x.cyc  = cyc_cnt;
        if (w) ref_mem[int'(a)] = d;
        sb.push_back(x);
    endtask

    // Scoreboard: push on every observed handshake, pop on every response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            check("ready_excl", 32'(req0_ready & req1_ready), 0);
            if (resp0_valid || resp1_valid) begin
                n_resp++;
                check("resp_one_port", 32'(resp0_valid & resp1_valid), 0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", {30'd0, resp1_valid, resp0_valid}, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", 32'(resp1_valid), 32'(e.port));
                    check("resp_rdata", e.port ? resp1_rdata : resp0_rdata, e.data);
                    check("resp_latency", cyc_cnt - e.cyc, LAT + 1);
                end
            end
            if (req0_valid && req0_ready) push(1'b0, req0_write, req0_addr, req0_wdata);
            if (req1_valid && req1_ready) push(1'b1, req1_write, req1_addr, req1_wdata);
        end
    end

    task automatic drive(input int p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called at the start of the first ACCESS cycle; returns at the start
    // of the IDLE cycle that follows the response.
    task automatic expect_access(input int p, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < LAT; i++) begin
            mid();
            check("acc_en", 32'(mem_en), 1);
            check("acc_we", 32'(mem_we), 32'(w));
            check("acc_addr", mem_addr, a);
            if (w) check("acc_wdata", mem_wdata, d);
            check("acc_busy", 32'(busy), 1);
            check("acc_ready", {30'd0, req1_ready, req0_ready}, 0);
            next_cycle();
        end
        mid();
        check("resp_en", 32'(mem_en), 0);
        check("resp_we", 32'(mem_we), 0);
        check("resp_addr_hold", mem_addr, a);
        check("resp_valid", {30'd0, resp1_valid, resp0_valid}, (p == 0) ? 1 : 2);
        check("resp_ready", {30'd0, req1_ready, req0_ready}, 0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with both requesters asking.
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (2) mid();
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_ready1", 32'(req1_ready), 0);
        check("rst_resp0_valid", 32'(resp0_valid), 0);
        check("rst_resp1_valid", 32'(resp1_valid), 0);
        check("rst_resp0_rdata", resp0_rdata, 0);
        check("rst_resp1_rdata", resp1_rdata, 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", 32'(busy), 0);

        next_cycle();
        rst_n = 1'b1;
        mid();
        check("rel_ready0", 32'(req0_ready), 1);
        check("rel_ready1", 32'(req1_ready), 0);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h30, 32'h0);
        expect_access(0, 1'b0, 32'h30, 32'h0);

        // Port 1 waited through port 0's transaction; single read of 0x10.
        mid();
        check("p1_ready", {30'd0, req1_ready, req0_ready}, 2);
        check("idle_busy", 32'(busy), 0);
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h10, 32'h0);
        expect_access(1, 1'b0, 32'h10, 32'h0);

        // Write then read back on port 0.
        drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        mid();
        check("wr_ready", {30'd0, req1_ready, req0_ready}, 1);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_access(0, 1'b1, 32'h20, 32'h1234_5678);
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        mid();
        check("rd_ready", {30'd0, req1_ready, req0_ready}, 1);
        check("p1_rdata_hold", resp1_rdata, 32'hDEAD_BEEF);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_access(0, 1'b0, 32'h20, 32'h0);

        // Late arrival: port 1 raises valid during port 0's access.
        drive(0, 1'b1, 1'b0, 32'h34, 32'h0);
        mid();
        check("late_ready0", {30'd0, req1_ready, req0_ready}, 1);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h38, 32'h0);
        expect_access(0, 1'b0, 32'h34, 32'h0);
        mid();
        check("late_ready1", {30'd0, req1_ready, req0_ready}, 2);
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_access(1, 1'b0, 32'h38, 32'h0);

        // Contention: port 1 went last, so grants run 0,1,0,1.
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h44, 32'h0);
        for (int t = 0; t < 4; t++) begin
            mid();
            check("rr_ready", {30'd0, req1_ready, req0_ready}, (t % 2 == 0) ? 1 : 2);
            if (t > 0) check("rr_gap", cyc_cnt - last_rdy, LAT + 2);
            last_rdy = cyc_cnt;
            next_cycle();
            if (t == 3) begin
                drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            expect_access(t % 2, 1'b0, (t % 2 == 0) ? 32'h40 : 32'h44, 32'h0);
        end

        // Reset in the second ACCESS cycle abandons the transaction.
        drive(0, 1'b1, 1'b0, 32'h3C, 32'h0);
        mid();
        check("midop_ready0", {30'd0, req1_ready, req0_ready}, 1);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        check("midop_acc_en", 32'(mem_en), 1);
        next_cycle();
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h48, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4C, 32'h0);
        #1;
        check("midop_en_drop", 32'(mem_en), 0);
        check("midop_busy_drop", 32'(busy), 0);
        repeat (3) begin
            mid();
            check("midop_no_resp", {30'd0, resp1_valid, resp0_valid}, 0);
        end
        next_cycle();
        rst_n = 1'b1;
        mid();
        check("midop_tie_p0", {30'd0, req1_ready, req0_ready}, 1);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_access(0, 1'b0, 32'h48, 32'h0);

        repeat (4) begin
            mid();
            check("idle_quiet", {30'd0, resp1_valid, resp0_valid}, 0);
            next_cycle();
        end
        check("sb_empty", sb.size(), 0);
        check("resp_count", n_resp, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares one single-port, fixed-latency data memory between requester 0 (instruction fetch) and requester 1 (load/store unit).
- Accepts one request at a time over a valid/ready handshake and drives the memory for MEM_LATENCY cycles.
- Returns a one-cycle response pulse to the requester that won.
- Round-robin priority prevents either requester from starving the other.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- MEM_LATENCY, 2, cycles the memory needs per access; legal range 1..15.
- CNT_WIDTH, 4, width of the latency counter; must satisfy 2**CNT_WIDTH > MEM_LATENCY.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has a pending request.
- req0_write_i  input  1  requester 0 request is a write (1) or a read (0).
- req0_addr_i  input  DATA_WIDTH  requester 0 byte address.
- req0_wdata_i  input  DATA_WIDTH  requester 0 write data.
- req0_ready_o  output  1  request 0 is accepted this cycle.
- resp0_valid_o  output  1  one-cycle completion pulse for requester 0.
- resp0_rdata_o  output  DATA_WIDTH  read data for requester 0.
- req1_* / resp1_*  same seven ports as requester 0, same widths and meaning.
- mem_en_o  output  1  memory access enable.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  DATA_WIDTH  memory address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_rdata_i  input  DATA_WIDTH  memory read data.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE, last_grant=1, so port 0 wins the first tie.
  - Counter=0.
  - All outputs are 0, including both response data buses.
  - Reset mid-transaction abandons it; no response is ever issued for it.
- FSM states and transitions:
  - IDLE -> ACCESS on handshake.
  - ACCESS -> RESP when counter == MEM_LATENCY-1.
  - RESP -> IDLE unconditionally.
- IDLE:
  - Grant is combinational. If only one valid is high, that port is granted.
  - If both are high, the port not equal to last_grant is granted.
  - reqN_ready_o = (state==IDLE) & grantN. At most one ready is high in any cycle.
  - Handshake is valid&ready. On handshake, latch write, address, wdata and port id; set last_grant=port; clear counter; go to ACCESS.
- ACCESS:
  - mem_en_o=1 and mem_we_o=latched write for all MEM_LATENCY cycles.
  - mem_addr_o and mem_wdata_o are driven from the latch and stay stable.
  - Counter increments each cycle.
  - On the last cycle (counter==MEM_LATENCY-1), capture mem_rdata_i into the response register; the captured value is for reads only.
- RESP:
  - respN_valid_o=1 for exactly one cycle on the latched port only.
  - respN_rdata_o = captured data for a read, 0 for a write; a write still produces the acknowledge pulse.
- Latency and throughput:
  - Handshake in cycle A gives resp_valid in cycle A+MEM_LATENCY+1.
  - Peak throughput is one transaction per MEM_LATENCY+2 cycles.
- Outside ACCESS, mem_en_o and mem_we_o are 0; the mem address and data outputs hold their last value.
- respN_rdata_o holds its value between pulses and is valid only while respN_valid_o is high.
- Requester contract:
  - Hold valid and its fields stable until ready is seen.
  - A request raised during ACCESS or RESP waits; it is never dropped.
  - Changes to the inputs after acceptance have no effect.
- busy_o = (state != IDLE).

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Packed struct mem_req_t {write, addr, wdata}.
  - Port id type.
- One sub-module: rr_arbiter2.
  - Holds the last_grant register.
  - Computes the combinational grant from the two valids.
  - Updates last_grant on an update strobe.

Test Plan:
- Reset: hold rst_n=0 with both valids high -> all outputs 0; release reset -> req0_ready_o=1 in the first cycle, req1_ready_o=0.
- Single read, MEM_LATENCY=2: port 1 reads 0x0000_0010, memory returns 0xDEAD_BEEF -> mem_en_o high for 2 cycles with addr 0x10; resp1_valid_o pulses in cycle A+3 with 0xDEAD_BEEF; resp0_valid_o stays 0.
- Write then read-back: port 0 writes 0x1234_5678 to 0x20 -> mem_we_o high for 2 cycles, resp0_valid_o pulses with rdata 0; port 0 then reads 0x20 -> returns 0x1234_5678.
- Contention: both valids held high for 4 transactions -> grants alternate 0,1,0,1; each resp pulses on the matching port only; the gap between successive readies is exactly 4 cycles.
- Late arrival: port 1 raises valid during port 0's ACCESS -> req1_ready_o stays 0 until IDLE, then port 1 is granted, with no loss and no duplicate response.
- Reset mid-op: assert rst_n=0 in the second ACCESS cycle -> mem_en_o drops immediately, no resp pulse appears, and after release port 0 wins the first tie.
